// File: rtl/insn_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack channel, decoder
// valid/ready channel and the execute redirect. The master modport is the
// fetch unit; the slave modport is the surrounding memory/decoder/execute side.
interface insn_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        insn_valid;
    logic        insn_ready;
    logic [15:0] insn;
    logic [15:0] insn_ip;
    logic        redirect;
    logic [15:0] redirect_ip;

    modport master (
        output mem_req, mem_addr, insn_valid, insn, insn_ip,
        input  mem_ack, mem_rdata, insn_ready, redirect, redirect_ip
    );

    modport slave (
        input  mem_req, mem_addr, insn_valid, insn, insn_ip,
        output mem_ack, mem_rdata, insn_ready, redirect, redirect_ip
    );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch stage: issues one outstanding 16-bit read at a time,
// buffers returned words with their addresses in a DEPTH-entry prefetch FIFO
// and presents the head to the decoder. A redirect pulse flushes the FIFO and
// restarts fetch at the new target; an in-flight read is allowed to complete
// and its data is dropped.
// Optional feature: define IFETCH_BYPASS_EN to forward a returning word
// straight to the decoder when the FIFO is empty (zero-cycle fetch latency).
module insn_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    insn_fetch_if.master  bus
);

    localparam logic [15:0] NOP = 16'h7000;
    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic [15:0]   last_ip_q, last_ip_d;
    logic [2:0]    count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   fifo_addr_q [DEPTH];
    logic [15:0]   fifo_addr_d [DEPTH];
    logic [15:0]   fifo_data_q [DEPTH];
    logic [15:0]   fifo_data_d [DEPTH];

    logic          fifo_empty;
    logic          bypass_hit;
    logic          ack_ok;
    logic          push;
    logic          pop;
    logic [2:0]    count_next;
    logic          space;
    logic [15:0]   rip;
    logic          valid_c;
    logic [15:0]   insn_c;
    logic [15:0]   insn_ip_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign rip        = {bus.redirect_ip[15:1], 1'b0};
    assign fifo_empty = (count_q == 3'd0);
    assign ack_ok     = (state_q == REQ) && bus.mem_ack && !bus.redirect;

`ifdef IFETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && ack_ok;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word that the decoder takes this cycle never enters the FIFO.
    assign push       = ack_ok && !(bypass_hit && bus.insn_ready);
    assign pop        = !fifo_empty && bus.insn_ready;
    assign count_next = count_q - 3'(pop) + 3'(push);
    assign space      = (count_next < 3'(DEPTH));

    // Decoder-facing view: bypass word, FIFO head, or NOP with the last address.
    always_comb begin
        valid_c   = 1'b0;
        insn_c    = NOP;
        insn_ip_c = last_ip_q;
        if (bypass_hit) begin
            valid_c   = 1'b1;
            insn_c    = bus.mem_rdata;
            insn_ip_c = mem_addr_q;
        end else if (!fifo_empty) begin
            valid_c   = 1'b1;
            insn_c    = fifo_data_q[rd_ptr_q];
            insn_ip_c = fifo_addr_q[rd_ptr_q];
        end
    end

    // Next-state for the prefetch FIFO and the fetch request FSM.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetch_ip_d  = fetch_ip_q;
        last_ip_d   = valid_c ? insn_ip_c : last_ip_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;

        if (bus.redirect) begin
            count_d  = 3'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                fifo_addr_d[wr_ptr_q] = mem_addr_q;
                fifo_data_d[wr_ptr_q] = bus.mem_rdata;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_next;
        end

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (bus.redirect) begin
                    fetch_ip_d = rip;
                end else if (space) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_ip_q;
                end
            end
            REQ: begin
                if (bus.mem_ack && !bus.redirect) begin
                    fetch_ip_d = fetch_ip_q + 16'd2;
                    if (space) begin
                        mem_addr_d = fetch_ip_q + 16'd2;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (bus.mem_ack) begin
                    fetch_ip_d = rip;
                    mem_addr_d = rip;
                end else if (bus.redirect) begin
                    fetch_ip_d = rip;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                // The old request stays up until memory answers it.
                if (bus.mem_ack) begin
                    state_d    = REQ;
                    fetch_ip_d = bus.redirect ? rip : fetch_ip_q;
                    mem_addr_d = bus.redirect ? rip : fetch_ip_q;
                end else if (bus.redirect) begin
                    fetch_ip_d = rip;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_IP;
            fetch_ip_q  <= RESET_IP;
            last_ip_q   <= 16'h0000;
            count_q     <= 3'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_addr_q <= '{default: 16'h0000};
            fifo_data_q <= '{default: 16'h0000};
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetch_ip_q  <= fetch_ip_d;
            last_ip_q   <= last_ip_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.insn_valid = valid_c;
    assign bus.insn       = insn_c;
    assign bus.insn_ip    = insn_ip_c;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch (DEPTH=2, RESET_IP=0). A small memory model
// answers each request after 'lat' cycles with data = ~address.
module tb_insn_fetch;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat    = 1;

    insn_fetch_if bus();

    insn_fetch #(.DEPTH(2), .RESET_IP(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   16'(bus.mem_req),    16'h0000);
        chk({tag, "_addr"},  bus.mem_addr,        16'h0000);
        chk({tag, "_valid"}, 16'(bus.insn_valid), 16'h0000);
        chk({tag, "_insn"},  bus.insn,            16'h7000);
        chk({tag, "_ip"},    bus.insn_ip,         16'h0000);
    endtask

    // Memory: acks the lat-th cycle of each request, data is ~addr.
    initial begin
        int w;
        w = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            if (!bus.mem_req) begin
                bus.mem_ack = 1'b0;
                w = 0;
            end else begin
                if (bus.mem_ack) w = 0;
                w++;
                bus.mem_ack   = (w >= lat);
                bus.mem_rdata = ~bus.mem_addr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.insn_ready  = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_ip = 16'h0000;
        lat             = 1;

        step();
        chk_reset("reset");

`ifdef IFETCH_BYPASS_EN
        // Bypass: empty FIFO, ack with insn_ready -> same-cycle valid.
        rst = 1'b0;
        step();
        chk("byp_valid0", 16'(bus.insn_valid), 16'h0001);
        chk("byp_insn0",  bus.insn,            16'hFFFF);
        chk("byp_ip0",    bus.insn_ip,         16'h0000);
        chk("byp_addr0",  bus.mem_addr,        16'h0000);
        step();
        chk("byp_valid1", 16'(bus.insn_valid), 16'h0001);
        chk("byp_insn1",  bus.insn,            16'hFFFD);
        chk("byp_ip1",    bus.insn_ip,         16'h0002);
        bus.insn_ready = 1'b0;
        step();
        chk("byp_buf_valid", 16'(bus.insn_valid), 16'h0001);
        chk("byp_buf_ip",    bus.insn_ip,         16'h0002);
        chk("byp_buf_insn",  bus.insn,            16'hFFFD);
        chk("byp_buf_addr",  bus.mem_addr,        16'h0004);
`else
        // Streaming with single-cycle ack.
        rst = 1'b0;
        step();
        chk("t1_req",   16'(bus.mem_req),    16'h0001);
        chk("t1_addr",  bus.mem_addr,        16'h0000);
        chk("t1_valid", 16'(bus.insn_valid), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_s_valid", 16'(bus.insn_valid), 16'h0001);
            chk("t1_s_ip",    bus.insn_ip,         16'(2 * i));
            chk("t1_s_insn",  bus.insn,            ~16'(2 * i));
            chk("t1_s_addr",  bus.mem_addr,        16'(2 * i + 2));
        end

        // Decoder stalled: FIFO fills to 2, request drops, then drains in order.
        bus.insn_ready = 1'b0;
        do_reset();
        step();
        chk("t2_addr0", bus.mem_addr, 16'h0000);
        step();
        chk("t2_ip0",   bus.insn_ip,  16'h0000);
        chk("t2_addr1", bus.mem_addr, 16'h0002);
        step();
        chk("t2_full_req", 16'(bus.mem_req), 16'h0000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_req", 16'(bus.mem_req),    16'h0000);
            chk("t2_hold_ip",  bus.insn_ip,         16'h0000);
            chk("t2_hold_vld", 16'(bus.insn_valid), 16'h0001);
        end
        bus.insn_ready = 1'b1;
        step();
        chk("t2_pop_ip",   bus.insn_ip,      16'h0002);
        chk("t2_pop_insn", bus.insn,         16'hFFFD);
        chk("t2_pop_req",  16'(bus.mem_req), 16'h0001);
        chk("t2_pop_addr", bus.mem_addr,     16'h0004);
        step();
        chk("t2_res_ip",   bus.insn_ip,  16'h0004);
        chk("t2_res_addr", bus.mem_addr, 16'h0006);

        // 3-cycle memory, redirect while the read of 0004 is pending.
        lat = 3;
        do_reset();
        step();
        chk("t3_addr0", bus.mem_addr, 16'h0000);
        step();
        step();
        chk("t3_wait_vld", 16'(bus.insn_valid), 16'h0000);
        step();
        chk("t3_v0_ip",   bus.insn_ip,         16'h0000);
        chk("t3_v0_vld",  16'(bus.insn_valid), 16'h0001);
        step();
        chk("t3_empty_insn", bus.insn,    16'h7000);
        chk("t3_empty_ip",   bus.insn_ip, 16'h0000);
        step();
        step();
        chk("t3_addr4", bus.mem_addr, 16'h0004);
        chk("t3_ip2",   bus.insn_ip,  16'h0002);
        bus.redirect    = 1'b1;
        bus.redirect_ip = 16'h0101;
        step();
        bus.redirect = 1'b0;
        chk("t3_disc_req",  16'(bus.mem_req),    16'h0001);
        chk("t3_disc_addr", bus.mem_addr,        16'h0004);
        chk("t3_disc_vld",  16'(bus.insn_valid), 16'h0000);
        chk("t3_disc_ip",   bus.insn_ip,         16'h0002);
        step();
        chk("t3_disc_addr2", bus.mem_addr, 16'h0004);
        step();
        chk("t3_new_addr", bus.mem_addr,        16'h0100);
        chk("t3_drop_vld", 16'(bus.insn_valid), 16'h0000);
        step();
        step();
        chk("t3_wait2_vld", 16'(bus.insn_valid), 16'h0000);
        step();
        chk("t3_first_vld",  16'(bus.insn_valid), 16'h0001);
        chk("t3_first_ip",   bus.insn_ip,         16'h0100);
        chk("t3_first_insn", bus.insn,            16'hFEFF);

        // Redirect coincident with ack and insn_ready.
        lat = 1;
        do_reset();
        step();
        step();
        chk("t4_head_ip", bus.insn_ip, 16'h0000);
        bus.redirect    = 1'b1;
        bus.redirect_ip = 16'h0200;
        step();
        bus.redirect = 1'b0;
        chk("t4_flush_vld",  16'(bus.insn_valid), 16'h0000);
        chk("t4_flush_insn", bus.insn,            16'h7000);
        chk("t4_req",        16'(bus.mem_req),    16'h0001);
        chk("t4_addr",       bus.mem_addr,        16'h0200);
        step();
        chk("t4_ip",   bus.insn_ip, 16'h0200);
        chk("t4_insn", bus.insn,    16'hFDFF);

        // Wrap: redirect to FFFD (bit0 dropped), fetch FFFC, FFFE, 0000.
        bus.redirect    = 1'b1;
        bus.redirect_ip = 16'hFFFD;
        step();
        bus.redirect = 1'b0;
        chk("t5_addr_fffc", bus.mem_addr, 16'hFFFC);
        step();
        chk("t5_addr_fffe", bus.mem_addr, 16'hFFFE);
        chk("t5_ip_fffc",   bus.insn_ip,  16'hFFFC);
        step();
        chk("t5_addr_wrap", bus.mem_addr, 16'h0000);
        chk("t5_ip_fffe",   bus.insn_ip,  16'hFFFE);
        chk("t5_insn",      bus.insn,     16'h0001);

        // Reset asserted while in DISCARD.
        lat = 3;
        do_reset();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_ip = 16'h0300;
        step();
        bus.redirect = 1'b0;
        chk("t6_disc_req",  16'(bus.mem_req), 16'h0001);
        chk("t6_disc_addr", bus.mem_addr,     16'h0000);
        rst = 1'b1;
        #1;
        chk_reset("t6_rst");
        step();
        rst = 1'b0;
        step();
        chk("t6_restart_req",  16'(bus.mem_req), 16'h0001);
        chk("t6_restart_addr", bus.mem_addr,     16'h0000);
        step();
        step();
        step();
        chk("t6_restart_vld", 16'(bus.insn_valid), 16'h0001);
        chk("t6_restart_ip",  bus.insn_ip,         16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
